// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state, transaction owner,
// downstream size encodings and the starvation counter width helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   // log2 of the access size in bytes
   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   // Width needed to hold 0..max inclusive.
   function automatic int cnt_width(input int max);
      if (max < 1) return 1;
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_select.sv
// Combinational winner pick between ifetch and dmem. dmem wins by default;
// ifetch wins when dmem is idle or when it has been starved STARVE_MAX times.
// Grants are one-hot, or none when nobody requests.
module mem_arb_select
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 3
) (
   input  logic             ifetch_valid_i,
   input  logic             dmem_valid_i,
   input  logic [CNT_W-1:0] starve_cnt_i,
   output logic             grant_i_o,
   output logic             grant_d_o
);

   // Pick rule: starvation override first, then dmem priority.
   always_comb begin
      grant_i_o = ifetch_valid_i &
                  (~dmem_valid_i | (starve_cnt_i == CNT_W'(STARVE_MAX)));
      grant_d_o = dmem_valid_i & ~grant_i_o;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-beat memory port between the fetch port and the
// load/store port. One transaction in flight: IDLE latches the winner,
// REQ presents it downstream, WAIT collects the response, RESP pulses the
// owner's data_ok for one cycle.
//
// Handshake: a downstream request transfers on the cycle m_valid & m_ready
// are both high; m_valid and all m_* fields are held stable until then.
// m_resp_valid is only honoured in WAIT. Requesters hold their valid until
// their data_ok pulse; dropping it earlier does not abort the transaction.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 64,
   parameter int DATA_W     = 64,
   parameter int STARVE_MAX = 4,
   localparam int CNT_W     = cnt_width(STARVE_MAX)
) (
   input  logic                clk,
   input  logic                reset,
   // fetch port
   input  logic                i_valid,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic                i_data_ok,
   output logic [31:0]         i_data,
   // load/store port
   input  logic                d_valid,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [2:0]          d_size,
   input  logic [DATA_W/8-1:0] d_strobe,
   input  logic [DATA_W-1:0]   d_wdata,
   output logic                d_data_ok,
   output logic [DATA_W-1:0]   d_rdata,
   // downstream port
   output logic                m_valid,
   output logic                m_write,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [2:0]          m_size,
   output logic [DATA_W/8-1:0] m_strobe,
   output logic [DATA_W-1:0]   m_wdata,
   input  logic                m_ready,
   input  logic                m_resp_valid,
   input  logic [DATA_W-1:0]   m_rdata,
   // debug visibility
   output arb_state_t          dbg_state_o,
   output logic [CNT_W-1:0]    dbg_starve_cnt_o
);

   arb_state_t          state_q, state_d;
   owner_t              owner_q;
   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          size_q;
   logic [DATA_W/8-1:0] strobe_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    starve_cnt_q;
   logic [31:0]         i_data_q;
   logic [DATA_W-1:0]   d_rdata_q;
   logic                grant_i, grant_d;

   mem_arb_select #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_select (
      .ifetch_valid_i (i_valid),
      .dmem_valid_i   (d_valid),
      .starve_cnt_i   (starve_cnt_q),
      .grant_i_o      (grant_i),
      .grant_d_o      (grant_d)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state and handshake outputs; reset forces the outputs low at once.
   always_comb begin
      state_d   = state_q;
      m_valid   = 1'b0;
      i_data_ok = 1'b0;
      d_data_ok = 1'b0;
      case (state_q)
         IDLE: if (grant_i | grant_d) state_d = REQ;
         REQ: begin
            m_valid = ~reset;
            if (m_ready) state_d = WAIT;
         end
         WAIT: if (m_resp_valid) state_d = RESP;
         RESP: begin
            i_data_ok = ~reset & (owner_q == OWN_I);
            d_data_ok = ~reset & (owner_q == OWN_D);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Latch the winning request in IDLE; fetches become fixed 4-byte reads.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= OWN_I;
         write_q  <= 1'b0;
         addr_q   <= '0;
         size_q   <= '0;
         strobe_q <= '0;
         wdata_q  <= '0;
      end else if (state_q == IDLE) begin
         if (grant_i) begin
            owner_q  <= OWN_I;
            write_q  <= 1'b0;
            addr_q   <= i_addr;
            size_q   <= MSIZE4;
            strobe_q <= '0;
            wdata_q  <= '0;
         end else if (grant_d) begin
            owner_q  <= OWN_D;
            write_q  <= d_write;
            addr_q   <= d_addr;
            size_q   <= d_size;
            strobe_q <= d_strobe;
            wdata_q  <= d_wdata;
         end
      end
   end

   // Starvation counter: counts dmem grants that bypassed a pending fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else if (state_q == IDLE) begin
         if (grant_i) begin
            starve_cnt_q <= '0;
         end else if (grant_d) begin
            if (!i_valid)
               starve_cnt_q <= '0;
            else if (starve_cnt_q != CNT_W'(STARVE_MAX))
               starve_cnt_q <= starve_cnt_q + CNT_W'(1);
         end
      end
   end

   // Capture response data for the owner only; it holds until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         i_data_q  <= '0;
         d_rdata_q <= '0;
      end else if (state_q == WAIT && m_resp_valid) begin
         if (owner_q == OWN_I) i_data_q  <= m_rdata[{addr_q[2], 5'd0} +: 32];
         else                  d_rdata_q <= m_rdata;
      end
   end

   assign m_write          = write_q;
   assign m_addr           = addr_q;
   assign m_size           = size_q;
   assign m_strobe         = strobe_q;
   assign m_wdata          = wdata_q;
   assign i_data           = i_data_q;
   assign d_rdata          = d_rdata_q;
   assign dbg_state_o      = state_q;
   assign dbg_starve_cnt_o = starve_cnt_q;

endmodule
